// File: rtl/s7_frame_align.sv
// s7_frame_align: bitslip controller aligning ISERDES frame-clock words.
// Define S7_FRAME_ALIGN_ERRCNT_EN to add the err_count port and counter.
module s7_frame_align #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] PATTERN   = 8'hF0,
  parameter int unsigned      SETTLE    = 16,
  parameter int unsigned      LOCK_CNT  = 64,
  parameter int unsigned      MAX_SLIPS = 16,
  localparam int unsigned     SW = $clog2(MAX_SLIPS + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             enable,
  input  logic             frame_valid,
  input  logic [WIDTH-1:0] frame_word,
  output logic             bitslip,
  output logic             aligned,
  output logic             fail,
  output logic [SW-1:0]    slip_count
`ifdef S7_FRAME_ALIGN_ERRCNT_EN
  ,
  output logic [15:0]      err_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_LOCKED,
    S_FAIL
  } state_t;

  localparam logic [7:0]    SETTLE_V = 8'(SETTLE);
  localparam logic [15:0]   LOCK_V   = 16'(LOCK_CNT);
  localparam logic [SW-1:0] SLIP_MAX = SW'(MAX_SLIPS);

  state_t        state_q, state_d;
  logic [7:0]    settle_q, settle_d;
  logic [15:0]   match_q, match_d;
  logic [SW-1:0] slip_q, slip_d;
  logic          bitslip_q, bitslip_d;
  logic          aligned_q, aligned_d;
  logic          fail_q, fail_d;
  logic          hit;

  assign hit = (frame_word == PATTERN);

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    match_d   = match_q;
    slip_d    = slip_q;
    bitslip_d = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      slip_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d  = S_SETTLE;
          settle_d = SETTLE_V;
          match_d  = '0;
          slip_d   = '0;
        end
        S_SETTLE: begin
          if (frame_valid) begin
            settle_d = settle_q - 8'd1;
            if (settle_q == 8'd1) state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (frame_valid) begin
            if (hit) begin
              match_d = match_q + 16'd1;
              if (match_q + 16'd1 == LOCK_V) state_d = S_LOCKED;
            end else if (slip_q == SLIP_MAX) begin
              state_d = S_FAIL;
            end else begin
              bitslip_d = 1'b1;
              slip_d    = slip_q + SW'(1);
              match_d   = '0;
              settle_d  = SETTLE_V;
              state_d   = S_SETTLE;
            end
          end
        end
        S_LOCKED: begin
          // losing lock re-enters CHECK without slipping
          if (frame_valid && !hit) begin
            match_d = '0;
            slip_d  = '0;
            state_d = S_CHECK;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: state_d = S_IDLE;
      endcase
    end
    aligned_d = (state_d == S_LOCKED);
    fail_d    = (state_d == S_FAIL);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      match_q   <= '0;
      slip_q    <= '0;
      bitslip_q <= 1'b0;
      aligned_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      match_q   <= match_d;
      slip_q    <= slip_d;
      bitslip_q <= bitslip_d;
      aligned_q <= aligned_d;
      fail_q    <= fail_d;
    end
  end

  assign bitslip    = bitslip_q;
  assign aligned    = aligned_q;
  assign fail       = fail_q;
  assign slip_count = slip_q;

`ifdef S7_FRAME_ALIGN_ERRCNT_EN
  logic [15:0] err_q;
  logic        err_hit;

  assign err_hit = enable && (state_q == S_LOCKED)
                 && frame_valid && !hit;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_q <= '0;
    end else if (err_hit && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_s7_frame_align.sv
// tb_s7_frame_align: scoreboard bench for s7_frame_align.
// Reference model predicts registered outputs every cycle.
module tb_s7_frame_align;

  localparam logic [7:0] PAT = 8'hF0;
  localparam int ST = 4;
  localparam int LK = 8;
  localparam int MX = 16;
  localparam int SW = $clog2(MX + 1);

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          enable = 1'b0;
  logic          frame_valid = 1'b0;
  logic [7:0]    frame_word = 8'h00;
  logic          bitslip;
  logic          aligned;
  logic          fail;
  logic [SW-1:0] slip_count;
`ifdef S7_FRAME_ALIGN_ERRCNT_EN
  logic [15:0]   err_count;
`endif

  s7_frame_align #(
    .WIDTH(8),
    .PATTERN(PAT),
    .SETTLE(ST),
    .LOCK_CNT(LK),
    .MAX_SLIPS(MX)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .enable(enable),
    .frame_valid(frame_valid),
    .frame_word(frame_word),
    .bitslip(bitslip),
    .aligned(aligned),
    .fail(fail),
    .slip_count(slip_count)
`ifdef S7_FRAME_ALIGN_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  typedef struct packed {
    logic          bs;
    logic          al;
    logic          fl;
    logic [SW-1:0] sc;
    logic [15:0]   ec;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_new;
  exp_t e_cur;

  // Reference: phase 0 idle, 1 skipping, 2 hunting, 3 locked, 4 failed
  int m_phase = 0;
  int m_skip = 0;
  int m_run = 0;
  int m_slips = 0;
  int m_err = 0;
  bit m_bs = 0;

  always @(posedge sys_clk) begin
    m_bs = 0;
    if (sys_rst) begin
      m_phase = 0; m_skip = 0; m_run = 0; m_slips = 0; m_err = 0;
    end else if (!enable) begin
      m_phase = 0; m_slips = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_skip = ST; m_run = 0; m_slips = 0;
    end else if (frame_valid) begin
      if (m_phase == 1) begin
        m_skip = m_skip - 1;
        if (m_skip == 0) m_phase = 2;
      end else if (m_phase == 2) begin
        if (frame_word == PAT) begin
          m_run = m_run + 1;
          if (m_run == LK) m_phase = 3;
        end else if (m_slips == MX) begin
          m_phase = 4;
        end else begin
          m_bs = 1;
          m_slips = m_slips + 1;
          m_run = 0;
          m_skip = ST;
          m_phase = 1;
        end
      end else if (m_phase == 3 && frame_word != PAT) begin
        m_run = 0;
        m_slips = 0;
        m_phase = 2;
        if (m_err < 65535) m_err = m_err + 1;
      end
    end
    e_new.bs = m_bs;
    e_new.al = (m_phase == 3);
    e_new.fl = (m_phase == 4);
    e_new.sc = SW'(m_slips);
    e_new.ec = 16'(m_err);
    exp_q.push_back(e_new);
  end

  always @(negedge sys_clk) begin
    if (exp_q.size() > 0) begin
      e_cur = exp_q.pop_front();
      chk("outputs{bs,al,fail,slips}",
          32'({bitslip, aligned, fail, slip_count}),
          32'({e_cur.bs, e_cur.al, e_cur.fl, e_cur.sc}));
`ifdef S7_FRAME_ALIGN_ERRCNT_EN
      chk("err_count", 32'(err_count), 32'(e_cur.ec));
`endif
    end
  end

  int mode = 0;
  int vmode = 0;
  int off = 0;
  int cyc = 0;
  int pulses = 0;
  bit inject = 0;

  task automatic step();
    logic [15:0] dbl;
    logic [7:0]  w;
    @(posedge sys_clk);
    #1;
    if (bitslip === 1'b1) begin
      pulses++;
      off = (off + 7) % 8;
    end
    cyc++;
    case (vmode)
      0: frame_valid = 1'b1;
      1: frame_valid = (cyc % 3 == 0);
      default: frame_valid = ($urandom_range(0, 9) < 7);
    endcase
    dbl = {PAT, PAT} << off;
    case (mode)
      0: w = PAT;
      1: w = dbl[15:8];
      2: w = 8'h00;
      default: w = ($urandom_range(0, 99) < 85) ? PAT : 8'($urandom);
    endcase
    if (inject && frame_valid) begin
      w = 8'hF1;
      inject = 0;
    end
    frame_word = w;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic restart(int m, int vm, int o);
    enable = 1'b0;
    run(2);
    mode = m;
    vmode = vm;
    off = o;
    pulses = 0;
    enable = 1'b1;
  endtask

  initial begin
    run(3);
    sys_rst = 1'b0;
    run(2);

    restart(0, 0, 0);
    run(20);
    chk("aligned_pulses", 32'(pulses), 32'd0);
    chk("aligned_lock", 32'(aligned), 32'd1);
    chk("aligned_slips", 32'(slip_count), 32'd0);

    pulses = 0;
    inject = 1;
    run(20);
    chk("corrupt_pulses", 32'(pulses), 32'd0);
    chk("corrupt_relock", 32'(aligned), 32'd1);
`ifdef S7_FRAME_ALIGN_ERRCNT_EN
    chk("corrupt_errcnt", 32'(err_count), 32'd1);
`endif

    restart(1, 0, 3);
    run(60);
    chk("rot_pulses", 32'(pulses), 32'd3);
    chk("rot_lock", 32'(aligned), 32'd1);
    chk("rot_slips", 32'(slip_count), 32'd3);

    restart(2, 0, 0);
    run(110);
    chk("zero_pulses", 32'(pulses), 32'd16);
    chk("zero_fail", 32'(fail), 32'd1);
    enable = 1'b0;
    step();
    chk("zero_clear",
        32'({bitslip, aligned, fail, slip_count}), 32'd0);

    restart(0, 1, 0);
    run(60);
    chk("sparse_lock", 32'(aligned), 32'd1);

    restart(1, 0, 3);
    for (int i = 0; i < 200 && pulses < 2; i++) step();
    chk("rst_two_slips", 32'(pulses), 32'd2);
    run(2);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    pulses = 0;
    run(40);
    chk("rst_pulses", 32'(pulses), 32'd1);
    chk("rst_lock", 32'(aligned), 32'd1);
    chk("rst_slips", 32'(slip_count), 32'd1);

    restart(3, 2, 0);
    for (int i = 0; i < 2000; i++) begin
      step();
      enable = ($urandom_range(0, 149) != 0);
      sys_rst = ($urandom_range(0, 599) == 0);
    end
    sys_rst = 1'b0;
    enable = 1'b0;
    run(3);
    @(negedge sys_clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
